// File: rtl/mem_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// mem_ctrl_arbiter
//
// Arbitrates whole-word instruction fetches and byte/half/word data loads and
// stores onto a single byte-wide synchronous RAM port. Multi-byte transfers
// are walked one byte per cycle; reads are assembled little-endian and
// zero-extended. Fetch responses carry the address they were fetched from so
// the requester can drop stale words after a redirect.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   inst_req/inst_addr fetch request (level) and word-aligned address
//   inst_o/inst_pc     fetched word and the address it came from
//   inst_done          one-cycle pulse, inst_o/inst_pc valid
//   data_req/data_we   load/store request (level), 1 = store
//   data_addr/data_len byte address, length code (0:1B, 1:2B, 2/3:4B)
//   data_wdata         store data, low bytes used
//   data_rdata         load data, zero-extended
//   data_done          one-cycle pulse, load data valid / store finished
//   mem_din            RAM read byte, valid the cycle after mem_a is presented
//   mem_dout/mem_a     RAM write byte and byte address
//   mem_wr             RAM write enable
// ---------------------------------------------------------------------------
module mem_ctrl_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_done,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_len,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_r;    // base address of the transfer in flight
    logic [2:0]        len_r;     // transfer length in bytes: 1, 2 or 4
    logic [2:0]        cnt;       // index of the next byte to present (k)
    logic              src_inst;  // 1 = fetch, 0 = data access
    logic [31:0]       wdata_r;
    logic [31:0]       rbuf;      // bytes captured so far, unused bytes stay 0

    logic [1:0]        cap_idx;
    logic [31:0]       rbuf_next;
    logic [7:0]        wbyte;
    logic [ADDR_W-1:0] next_a;
    logic [2:0]        req_len;

    // Byte k-1 is the one returning from the RAM on the edge where cnt == k.
    // cnt == 4 wraps to index 3 through the 2-bit subtraction.
    always_comb begin
        cap_idx   = cnt[1:0] - 2'd1;
        rbuf_next = rbuf;
        rbuf_next[{cap_idx, 3'b000} +: 8] = mem_din;
        wbyte     = wdata_r[{cnt[1:0], 3'b000} +: 8];
        next_a    = addr_r + ADDR_W'(cnt);  // wraps modulo 2^ADDR_W
        req_len   = (data_len == 2'd0) ? 3'd1 :
                    (data_len == 2'd1) ? 3'd2 : 3'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the datapath registers are few and feed outputs directly, so
        // they are all cleared by reset; every output must read 0 in reset.
        if (!rst) begin
            state      <= IDLE;
            addr_r     <= '0;
            len_r      <= '0;
            cnt        <= '0;
            src_inst   <= 1'b0;
            wdata_r    <= '0;
            rbuf       <= '0;
            inst_o     <= '0;
            inst_pc    <= '0;
            inst_done  <= 1'b0;
            data_rdata <= '0;
            data_done  <= 1'b0;
            mem_dout   <= '0;
            mem_a      <= '0;
            mem_wr     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in this block; the
            // defaults below are overridden later in the same edge, which
            // makes the done outputs single-cycle pulses.
            inst_done <= 1'b0;
            data_done <= 1'b0;

            case (state)
                IDLE: begin
                    // The done flags seen here are the registered pulses, so
                    // the edge that ends a done cycle never accepts.
                    if (!inst_done && !data_done && (data_req || inst_req)) begin
                        cnt  <= 3'd1;
                        rbuf <= '0;
                        if (data_req) begin
                            addr_r   <= data_addr;
                            mem_a    <= data_addr;
                            len_r    <= req_len;
                            src_inst <= 1'b0;
                            wdata_r  <= data_wdata;
                            if (data_we) begin
                                mem_wr   <= 1'b1;
                                mem_dout <= data_wdata[7:0];
                                state    <= WRITE;
                            end else begin
                                state    <= READ;
                            end
                        end else begin
                            addr_r   <= inst_addr;
                            mem_a    <= inst_addr;
                            len_r    <= 3'd4;
                            src_inst <= 1'b1;
                            state    <= READ;
                        end
                    end
                end

                READ: begin
                    rbuf <= rbuf_next;
                    if (cnt < len_r) begin
                        mem_a <= next_a;
                        cnt   <= cnt + 3'd1;
                    end else begin
                        mem_a <= '0;
                        state <= IDLE;
                        if (src_inst) begin
                            inst_o    <= rbuf_next;
                            inst_pc   <= addr_r;
                            inst_done <= 1'b1;
                        end else begin
                            data_rdata <= rbuf_next;
                            data_done  <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (cnt < len_r) begin
                        mem_a    <= next_a;
                        mem_dout <= wbyte;
                        mem_wr   <= 1'b1;
                        cnt      <= cnt + 3'd1;
                    end else begin
                        mem_wr    <= 1'b0;
                        mem_a     <= '0;
                        data_done <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl_arbiter
//
// Scoreboard bench. A driver issues rounds of requests (data only, fetch
// only, or both at once) and, at issue time, works out from a byte-array
// memory model what each response must be, in which order, and on which
// cycle. A negedge monitor pops and compares every done pulse and every RAM
// write. The RAM the design talks to is a separate array written only by the
// design, so a bad write shows up on a later read.
// ---------------------------------------------------------------------------
module tb_mem_ctrl_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        inst_done;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [1:0]  data_len;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_req  (inst_req),
        .inst_addr (inst_addr),
        .inst_o    (inst_o),
        .inst_pc   (inst_pc),
        .inst_done (inst_done),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_len  (data_len),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .data_done (data_done),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM seen by the design: 64 KiB, aliased on the low 16 address bits.
    logic [7:0] phys [0:65535];
    logic [7:0] model [0:65535];

    assign mem_din = phys[mem_a[15:0]];
    always @(posedge clk) if (mem_wr) phys[mem_a[15:0]] <= mem_dout;

    typedef struct {
        bit          is_inst;
        bit          is_store;
        logic [31:0] val;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        logic [31:0] ba;
        v = '0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            v[8*i +: 8] = model[ba[15:0]];
        end
        return v;
    endfunction

    function automatic int len_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (rst) begin
            if (inst_done || data_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: inst_done=%0b data_done=%0b with nothing outstanding", inst_done, data_done);
                end else begin
                    e = exp_q.pop_front();
                    check("done_source", {31'd0, inst_done}, {31'd0, e.is_inst});
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_inst) begin
                        check("inst_o", inst_o, e.val);
                        check("inst_pc", inst_pc, e.pc);
                    end else if (!e.is_store) begin
                        check("data_rdata", data_rdata, e.val);
                    end
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h byte 0x%02h", mem_a, mem_dout);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", mem_a, w.a);
                    check("wr_byte", {24'd0, mem_dout}, {24'd0, w.d});
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge. Predicts responses and their completion cycles,
    // raises the requests, and waits (bounded) for every done.
    task automatic do_round(input bit has_d, input bit we, input logic [31:0] da,
                            input logic [1:0] len, input logic [31:0] wd,
                            input bit has_i, input logic [31:0] ia,
                            input bit redirect, input logic [31:0] ia2, input bit drop);
        int          e0;
        int          n;
        int          budget;
        bit          d_pend;
        bit          i_pend;
        exp_t        e;
        wr_t         w;
        logic [31:0] ba;

        // A request raised during a done cycle is first accepted one edge later.
        e0 = cyc + ((inst_done || data_done) ? 2 : 1);
        n  = len_bytes(len);

        if (has_d) begin
            e.is_inst = 1'b0;
            e.is_store = we;
            e.pc = '0;
            e.cyc = e0 + n;
            if (we) begin
                e.val = '0;
                for (int i = 0; i < n; i++) begin
                    ba = da + 32'(i);
                    w.a = ba;
                    w.d = wd[8*i +: 8];
                    wr_q.push_back(w);
                    model[ba[15:0]] = w.d;
                end
            end else begin
                e.val = model_read(da, n);
            end
            exp_q.push_back(e);
        end
        if (has_i) begin
            e.is_inst = 1'b1;
            e.is_store = 1'b0;
            e.pc = ia;
            e.val = model_read(ia, 4);
            e.cyc = has_d ? (e0 + n + 2 + 4) : (e0 + 4);
            exp_q.push_back(e);
        end

        data_req   = has_d;
        data_we    = we;
        data_addr  = da;
        data_len   = len;
        data_wdata = wd;
        inst_req   = has_i;
        inst_addr  = ia;

        d_pend = has_d;
        i_pend = has_i;
        budget = 0;
        while ((d_pend || i_pend) && budget < 40) begin
            @(negedge clk);
            budget++;
            if (data_done) begin
                data_req = 1'b0;
                d_pend   = 1'b0;
            end
            if (inst_done) begin
                inst_req = 1'b0;
                i_pend   = 1'b0;
            end
            if (has_i && !has_d && cyc == e0 + 1) begin
                if (redirect) inst_addr = ia2;
                if (drop) inst_req = 1'b0;
            end
        end
        if (d_pend || i_pend) begin
            checks++;
            errors++;
            $display("FAIL timeout: data pending %0b inst pending %0b", d_pend, i_pend);
            data_req = 1'b0;
            inst_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FF00 : 32'h0000_1000;
        return base | 32'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [31:0] a;
        logic [7:0]  b;

        rst        = 1'b0;
        inst_req   = 1'b1;
        inst_addr  = 32'h100;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h3000;
        data_len   = 2'd2;
        data_wdata = 32'h1234_5678;

        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            phys[i]  = b;
            model[i] = b;
        end
        // Fetch target, byte load target.
        phys[16'h0100] = 8'h13; model[16'h0100] = 8'h13;
        phys[16'h0101] = 8'h05; model[16'h0101] = 8'h05;
        phys[16'h0102] = 8'h00; model[16'h0102] = 8'h00;
        phys[16'h0103] = 8'h00; model[16'h0103] = 8'h00;
        phys[16'h2000] = 8'hFF; model[16'h2000] = 8'hFF;

        // Reset held with both requests active: everything stays quiet.
        repeat (4) begin
            @(negedge clk);
            check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
            check("rst_mem_a", mem_a, 32'd0);
            check("rst_dones", {30'd0, inst_done, data_done}, 32'd0);
            check("rst_inst_o", inst_o, 32'd0);
        end

        // Release; the first request must be taken on the very next edge.
        @(negedge clk);
        rst      = 1'b1;
        data_req = 1'b0;
        do_round(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        check("fetch_word", inst_o, 32'h0000_0513);
        check("fetch_pc", inst_pc, 32'h100);

        // Simultaneous byte load and fetch: data wins, fetch follows.
        do_round(1, 0, 32'h2000, 2'd0, 32'hDEAD_BEEF, 1, 32'h104, 0, 0, 0);
        check("load_byte_held", data_rdata, 32'h0000_00FF);

        // Unaligned halfword store, then read it back.
        do_round(1, 1, 32'h3001, 2'd1, 32'hAABB_CCDD, 0, 0, 0, 0, 0);
        do_round(1, 0, 32'h3001, 2'd1, 32'h0, 0, 0, 0, 0, 0);
        check("store_readback", data_rdata, 32'h0000_CCDD);

        // Redirect mid-fetch: response keeps the old PC; next fetch uses the new one.
        do_round(0, 0, 0, 0, 0, 1, 32'h200, 1, 32'h400, 0);
        check("redirect_pc", inst_pc, 32'h200);
        do_round(0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0);
        check("after_redirect_pc", inst_pc, 32'h400);

        // Fetch whose request drops after acceptance still completes.
        do_round(0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 1);

        // Address wrap: word load and word store straddling all-ones.
        do_round(1, 0, 32'hFFFF_FFFE, 2'd3, 32'h0, 0, 0, 0, 0, 0);
        do_round(1, 1, 32'hFFFF_FFFF, 2'd2, 32'h0403_0201, 0, 0, 0, 0, 0);
        do_round(1, 0, 32'hFFFF_FFFF, 2'd2, 32'h0, 0, 0, 0, 0, 0);
        check("wrap_readback", data_rdata, 32'h0403_0201);

        // Reset two cycles into a 4-byte store.
        @(negedge clk);
        a = 32'h0000_4010;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = a;
        data_len   = 2'd2;
        data_wdata = 32'h9988_7766;
        wr_q.push_back('{a: a, d: 8'h66});
        wr_q.push_back('{a: a + 32'd1, d: 8'h77});
        model[a[15:0]] = 8'h66;  // only byte 0 reaches the RAM before reset
        @(negedge clk);
        @(negedge clk);
        #2;
        rst      = 1'b0;
        data_req = 1'b0;
        #1;
        check("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("midrst_mem_a", mem_a, 32'd0);
        check("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("midrst_data_done", {31'd0, data_done}, 32'd0);
        check("midrst_rdata", data_rdata, 32'd0);
        check("midrst_inst_pc", inst_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);  // monitor flags any late done or write
        do_round(1, 0, a, 2'd2, 32'h0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int r = 0; r < 200; r++) begin
            int          kind;
            logic [31:0] ia;
            kind = $urandom_range(0, 2);
            ia   = rand_addr() & 32'hFFFF_FFFC;
            do_round(kind != 1, 1'($urandom_range(0, 1)), rand_addr(), 2'($urandom_range(0, 3)),
                     $urandom, kind != 0, ia,
                     1'($urandom_range(0, 3) == 0), rand_addr() & 32'hFFFF_FFFC,
                     1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
